// File: rtl/sync_queue_if.sv
// Handshake and status bundle between a producer/consumer pair and sync_queue.
// master drives the push/pop/flush requests; slave is the queue itself.
interface sync_queue_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 10
);
  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_queue.sv
// Single-clock FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_queue #(
  parameter int WIDTH    = 8,
  parameter int AW       = 10,
  parameter int AF_LEVEL = (1 << AW) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic      clk,
  input  logic      reset,
  sync_queue_if.slave bus
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty_c;
  logic             full_c;
  logic             do_rd;
  logic             do_wr;

  // The wrap bit distinguishes full from empty when the addresses coincide.
  assign empty_c = (wp == rp);
  assign full_c  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_rd = bus.rd_en & ~empty_c;
  assign do_wr = bus.wr_en & (~full_c | do_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp          <= '0;
      rp          <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wp          <= '0;
      rp          <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wp <= wp + PTR_ONE;
      end
      if (do_rd) begin
        rp        <= rp + PTR_ONE;
        rd_data_q <= mem[rp[AW-1:0]];
      end
      rd_valid_q <= do_rd;

      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase

      if (bus.wr_en && !do_wr) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_c) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage is never reset; stale words are unreachable once the pointers move.
  always_ff @(posedge clk) begin
    if (do_wr && !bus.clear) begin
      mem[wp[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_queue.sv
// Directed plus randomized bench for sync_queue (AW=4, WIDTH=8) against a
// queue-based reference model of the FIFO's occupancy and flag rules.
module tb_sync_queue;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;

  logic clk;
  logic rst_n;

  sync_queue_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  sync_queue #(
    .WIDTH(WIDTH), .AW(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rd_data;
  bit               m_valid;
  bit               m_ovf;
  bit               m_unf;

  task automatic check_bit(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data = '0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
  endtask

  // The occupancy rules of the queue, expressed on a plain SV queue.
  task automatic model_step(bit wr, logic [WIDTH-1:0] wd, bit rd, bit clr);
    bit pop_ok;
    bit push_ok;
    if (clr) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      return;
    end
    pop_ok  = rd && (mq.size() > 0);
    push_ok = wr && ((mq.size() < DEPTH) || pop_ok);
    if (rd && mq.size() == 0) m_unf = 1'b1;
    if (wr && !push_ok)       m_ovf = 1'b1;
    m_valid = pop_ok;
    if (pop_ok)  m_rd_data = mq.pop_front();
    if (push_ok) mq.push_back(wd);
  endtask

  task automatic check_output(string tag);
    int sz;
    sz = mq.size();
    check_val({tag, ".count"},        32'(bus.count),    32'(sz));
    check_bit({tag, ".empty"},        bus.empty,         sz == 0);
    check_bit({tag, ".full"},         bus.full,          sz == DEPTH);
    check_bit({tag, ".almost_full"},  bus.almost_full,   sz >= AF);
    check_bit({tag, ".almost_empty"}, bus.almost_empty,  sz <= AE);
    check_bit({tag, ".overflow"},     bus.overflow,      m_ovf);
    check_bit({tag, ".underflow"},    bus.underflow,     m_unf);
    check_bit({tag, ".rd_valid"},     bus.rd_valid,      m_valid);
    check_val({tag, ".rd_data"},      32'(bus.rd_data),  32'(m_rd_data));
  endtask

  // Drive one cycle of requests, advance the model at the edge, check #1 later.
  task automatic apply_stimulus(string tag, bit wr, logic [WIDTH-1:0] wd, bit rd, bit clr);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    bus.clear   = clr;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(wr, wd, rd, clr);
    #1;
    check_output(tag);
  endtask

  initial begin
    bit wr;
    bit rd;
    bit clr;
    int bias;

    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'h3C;
    model_reset();
    $display("[TB] reset with push/pop requested");
    for (int i = 0; i < 3; i++) apply_stimulus("reset_hold", 1'b1, 8'h3C, 1'b1, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) apply_stimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] fill, overflow, drain");
    for (int i = 0; i < DEPTH; i++) apply_stimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    apply_stimulus("push_full", 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus("drained", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] simultaneous push/pop at full and at empty");
    apply_stimulus("clear_flags", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("refill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    apply_stimulus("pushpop_full", 1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("drain_aa", 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("last_word_aa", 32'(bus.rd_data), 32'h000000AA);
    apply_stimulus("pushpop_empty", 1'b1, 8'h55, 1'b1, 1'b0);

    $display("[TB] wrap-around at occupancy 3");
    apply_stimulus("occ2", 1'b1, 8'h56, 1'b0, 1'b0);
    apply_stimulus("occ3", 1'b1, 8'h57, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) apply_stimulus("wrap", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);

    $display("[TB] clear with push, then async reset");
    apply_stimulus("clear0", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) apply_stimulus("ovf_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) apply_stimulus("to_five", 1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus("clear_push", 1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus("refill5", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_reset");
    apply_stimulus("reset_low", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    apply_stimulus("post_reset_push", 1'b1, 8'h99, 1'b0, 1'b0);
    apply_stimulus("post_reset_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 40) % 2 == 0) ? 80 : 25;
      wr   = ($urandom_range(0, 99) < bias);
      rd   = ($urandom_range(0, 99) < (100 - bias));
      clr  = ($urandom_range(0, 149) == 0);
      apply_stimulus("random", wr, 8'($urandom), rd, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
